cla_seq_adder_ctrl: RTL

Multi-cycle sequencer that adds two WIDTH-bit operands through a single 2-bit carry-lookahead slice, two bits per clock, LSB pair first. It holds the operands, carries the slice carry-out between cycles, assembles the sum and reports completion with a ready/start/done handshake. It is the area-lean alternative to a full-width CLA and sits between a requesting controller and the register file.

---
 rtl/cla_seq_adder_ctrl_pkg.sv | 16 +
 rtl/cla_seq_adder_ctrl_cla2_slice.sv | 26 ++
 rtl/cla_seq_adder_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential 2-bit-slice CLA adder.
//   state_e  : controller FSM state encoding
//   width_ok : legality check for the WIDTH parameter (even and >= 2)
package cla_seq_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic bit width_ok(int unsigned w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla2_slice.sv
// Two-bit carry-lookahead adder slice.
//   a, b : 2-bit operand slices
//   cin  : carry into bit 0
//   s    : 2-bit sum
//   c    : c[0] = carry into bit 1, c[1] = slice carry-out
module cla2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic [1:0] c
);

  logic [1:0] p;
  logic [1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // Both carries computed directly from p/g/cin, no ripple through c[0].
  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);

  assign s = p ^ {c[0], cin};

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder: WIDTH-bit add through one 2-bit CLA slice, two bits per
// clock, LSB pair first, with a ready/start/done handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled only while ready=1
//   a, b, cin  : operands, captured on an accepted start
//   ready/busy : decoded from state (busy == RUN, ready == !busy)
//   done       : one-cycle pulse when sum/cout/ovf are valid
//   sum        : result, held until the next accepted start
//   cout, ovf  : carry out of bit WIDTH-1, signed overflow
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NSLICE - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $fatal(1, "cla_seq_adder_ctrl: WIDTH must be even and at least 2");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [CW:0] base;
  logic [1:0]  sl_a;
  logic [1:0]  sl_b;
  logic [1:0]  sl_s;
  logic [1:0]  sl_c;

  // Bit offset of the current slice: 2*cnt.
  assign base = {cnt_q, 1'b0};
  assign sl_a = a_q[base +: 2];
  assign sl_b = b_q[base +: 2];

  cla2_slice u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .c   (sl_c)
  );

  assign busy  = (state_q == StRun);
  assign ready = (state_q != StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          // DONE accepts directly so back-to-back adds need no idle bubble.
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum[base +: 2] <= sl_s;
          carry_q        <= sl_c[1];
          if (cnt_q == LastCnt) begin
            cout    <= sl_c[1];
            // Carry into the MSB xor carry out of it.
            ovf     <= sl_c[0] ^ sl_c[1];
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
